mm_job_sequencer: RTL and testbench
===================================

# mm_job_sequencer

Top-level job controller for the matrix multiplier. It accepts one C = A×B job (A is m×n, B is n×p) per configuration handshake and validates the dimensions against the array geometry. It then sequences one job: clear the systolic array, start the A and B address generators together, wait for both to finish, drain the array pipeline, trigger result write-back, and report completion or error. It sits between the config/register interface and the address generators, systolic array and write-back unit.

## Interface
- ARRAY_HEIGHT, 4, PE rows; power of two
- ARRAY_WIDTH, 4, PE columns; power of two
- BUFFER_ADDRESS_WIDTH, 10, operand buffer address width
- DRAIN_CYCLES, ARRAY_HEIGHT+ARRAY_WIDTH, cycles array_en stays high after both generators finish; ≥1
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  high only in IDLE
- cfg_m, cfg_n, cfg_p  in  16 each  job dimensions, sampled on handshake
- gen_m, gen_n, gen_p  out  16 each  registered job dimensions, stable from accept until the next accept
- gen_start  out  1  one-cycle start pulse to the A and B address generators
- a_done, b_done  in  1 each  single-cycle done pulses from the generators
- array_clear  out  1  one-cycle accumulator clear
- array_en  out  1  systolic array advance enable
- wb_start  out  1  one-cycle write-back start pulse
- wb_done  in  1  write-back complete pulse
- abort  in  1  synchronous job cancel
- busy  out  1  state ≠ IDLE
- job_done  out  1  one-cycle success pulse
- error  out  1  sticky error flag
- err_code  out  2  0 none, 1 zero dimension, 2 misaligned dimension, 3 aborted

## Operation
- FSM states: IDLE, CHECK, CLEAR, RUN, DRAIN, WB, FIN, ERR. All outputs are Moore-decoded from the state or are registers.
- IDLE: cfg_ready=1. When cfg_valid is high, latch the dimensions into gen_*, clear error and err_code, and go to CHECK.
- CHECK (1 cycle): go to ERR with code 1 if any of m, n, p is 0. Otherwise go to ERR with code 2 if m mod ARRAY_HEIGHT ≠ 0, p mod ARRAY_WIDTH ≠ 0, or n > 2^BUFFER_ADDRESS_WIDTH. Otherwise go to CLEAR. Code 1 takes priority over code 2.
- CLEAR (1 cycle): array_clear=1, then go to RUN.
- RUN: gen_start=1 on the first RUN cycle only; array_en=1 throughout.
  - a_done and b_done are captured into sticky flags, in either order and including the same cycle.
  - A pulse arriving in the same cycle the last flag would be set counts immediately.
  - Go to DRAIN on the cycle after both flags are set. Pulses outside RUN are ignored.
- DRAIN: array_en=1; a down-counter loads DRAIN_CYCLES on entry; go to WB after exactly DRAIN_CYCLES cycles in DRAIN.
- WB: wb_start=1 on the first WB cycle only; array_en=0; wait for wb_done, which may arrive on the wb_start cycle itself; then go to FIN.
- FIN (1 cycle): job_done=1, then go to IDLE.
- ERR (1 cycle): error=1 with err_code set, then go to IDLE. error and err_code remain set until the next accepted job.
- abort: in any state other than IDLE, go to IDLE next cycle and set error=1 with err_code=3. No job_done, wb_start or gen_start is issued on that cycle. abort in IDLE is ignored. abort wins over all simultaneous events.
- Done flags and the drain counter clear on every entry to CLEAR.

## Timing
- Reset: state IDLE.
  - cfg_ready=1; all other outputs 0, including gen_m, gen_n, gen_p and err_code.
- Handshake on edge T0: CHECK in cycle T0+1, array_clear in T0+2, gen_start in T0+3.
- Error path: error rises at T0+2 and cfg_ready returns at T0+3.
- Last generator done pulse in cycle R: DRAIN spans R+1 … R+DRAIN_CYCLES, wb_start at R+DRAIN_CYCLES+1.
- wb_done in cycle W: job_done at W+1, cfg_ready at W+2.
- Reset asserted mid-job returns everything to reset values immediately; no pulses are emitted.

## Test plan
- m=8, n=5, p=4, a_done@T0+10, b_done@T0+12 -> exactly one gen_start@T0+3; array_en high T0+3…T0+20; wb_start@T0+21; with wb_done@T0+25, job_done@T0+26.
- a_done and b_done in the same cycle; then b_done before a_done -> DRAIN entered the cycle after the later pulse in both cases.
- m=0, n=5, p=4 -> err_code=1, no gen_start, cfg_ready back in 3 cycles; then m=6, n=5, p=4 -> err_code=2. The next valid job clears error on accept.
- n=1024 accepted; n=1025 -> err_code=2 (BUFFER_ADDRESS_WIDTH=10).
- abort during DRAIN -> IDLE next cycle, err_code=3, no wb_start; a stray a_done in IDLE has no effect.
- reset_n asserted during WB -> all outputs at reset values immediately; a fresh job then completes normally.

Source files
------------

// File: rtl/mm_job_sequencer_if.sv
// Configuration handshake between the register block and the job sequencer.
// The register side is the master: it offers a job (valid + m/n/p) and the
// sequencer answers with ready while it is idle.
interface mm_job_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_m;
    logic [15:0] cfg_n;
    logic [15:0] cfg_p;

    modport master (
        output cfg_valid,
        output cfg_m,
        output cfg_n,
        output cfg_p,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_m,
        input  cfg_n,
        input  cfg_p,
        output cfg_ready
    );
endinterface

// File: rtl/mm_job_sequencer.sv
// Job controller for the matrix multiplier.
// Accepts one C = A x B job, checks its dimensions against the array
// geometry, then walks it through clear -> run -> drain -> write-back.
// All outputs are registers updated alongside the state, so every pulse is
// glitch-free and lines up with the state it belongs to.
module mm_job_sequencer #(
    parameter int ARRAY_HEIGHT         = 4,
    parameter int ARRAY_WIDTH          = 4,
    parameter int BUFFER_ADDRESS_WIDTH = 10,
    parameter int DRAIN_CYCLES         = ARRAY_HEIGHT + ARRAY_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mm_job_sequencer_if.slave     cfg,
    output logic [15:0]           o_gen_m,
    output logic [15:0]           o_gen_n,
    output logic [15:0]           o_gen_p,
    output logic                  o_gen_start,
    input  logic                  i_a_done,
    input  logic                  i_b_done,
    output logic                  o_array_clear,
    output logic                  o_array_en,
    output logic                  o_wb_start,
    input  logic                  i_wb_done,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_job_done,
    output logic                  o_error,
    output logic [1:0]            o_err_code
);

    localparam int          CNT_W  = $clog2(DRAIN_CYCLES + 1);
    // Dimensions must be whole multiples of the array; both sizes are powers
    // of two, so the remainder is just the low bits.
    localparam logic [15:0] M_MASK = 16'(ARRAY_HEIGHT - 1);
    localparam logic [15:0] P_MASK = 16'(ARRAY_WIDTH - 1);
    // n may fill the operand buffer exactly, hence the extra bit.
    localparam logic [16:0] N_MAX  = 17'(1) << BUFFER_ADDRESS_WIDTH;

    localparam logic [1:0]  ERR_NONE  = 2'd0;
    localparam logic [1:0]  ERR_ZERO  = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;
    localparam logic [1:0]  ERR_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_WB,
        S_FIN,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [15:0]        r_m;
    logic [15:0]        r_n;
    logic [15:0]        r_p;
    logic               r_a_seen;
    logic               r_b_seen;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic               r_cfg_ready;
    logic               r_gen_start;
    logic               r_array_clear;
    logic               r_array_en;
    logic               r_wb_start;
    logic               r_busy;
    logic               r_job_done;
    logic               r_error;
    logic [1:0]         r_err_code;

    logic               w_dim_zero;
    logic               w_dim_misaligned;
    logic               w_a_all;
    logic               w_b_all;
    logic               w_both_done;
    logic               w_drain_last;

    assign w_dim_zero       = (r_m == 16'd0) || (r_n == 16'd0) || (r_p == 16'd0);
    assign w_dim_misaligned = ((r_m & M_MASK) != 16'd0) ||
                              ((r_p & P_MASK) != 16'd0) ||
                              ({1'b0, r_n} > N_MAX);

    // A done pulse in the same cycle as the other flag completes the pair
    // without waiting for the flag register to update.
    assign w_a_all      = r_a_seen | i_a_done;
    assign w_b_all      = r_b_seen | i_b_done;
    assign w_both_done  = w_a_all & w_b_all;
    assign w_drain_last = (r_drain_cnt == CNT_W'(1));

    assign cfg.cfg_ready  = r_cfg_ready;
    assign o_gen_m        = r_m;
    assign o_gen_n        = r_n;
    assign o_gen_p        = r_p;
    assign o_gen_start    = r_gen_start;
    assign o_array_clear  = r_array_clear;
    assign o_array_en     = r_array_en;
    assign o_wb_start     = r_wb_start;
    assign o_busy         = r_busy;
    assign o_job_done     = r_job_done;
    assign o_error        = r_error;
    assign o_err_code     = r_err_code;

    // Job FSM: state, latched dimensions, done flags, drain counter and all
    // registered outputs advance together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_m           <= '0;
            r_n           <= '0;
            r_p           <= '0;
            r_a_seen      <= 1'b0;
            r_b_seen      <= 1'b0;
            r_drain_cnt   <= '0;
            r_cfg_ready   <= 1'b1;
            r_gen_start   <= 1'b0;
            r_array_clear <= 1'b0;
            r_array_en    <= 1'b0;
            r_wb_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_job_done    <= 1'b0;
            r_error       <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            // Pulses last one cycle unless a transition below re-asserts them.
            r_gen_start   <= 1'b0;
            r_array_clear <= 1'b0;
            r_wb_start    <= 1'b0;
            r_job_done    <= 1'b0;

            if (i_abort && (r_state != S_IDLE)) begin
                // Cancel overrides every other event this cycle.
                r_state     <= S_IDLE;
                r_cfg_ready <= 1'b1;
                r_busy      <= 1'b0;
                r_array_en  <= 1'b0;
                r_error     <= 1'b1;
                r_err_code  <= ERR_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg.cfg_valid) begin
                            r_m         <= cfg.cfg_m;
                            r_n         <= cfg.cfg_n;
                            r_p         <= cfg.cfg_p;
                            r_error     <= 1'b0;
                            r_err_code  <= ERR_NONE;
                            r_cfg_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_CHECK;
                        end
                    end

                    S_CHECK: begin
                        if (w_dim_zero) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_ZERO;
                            r_state    <= S_ERR;
                        end else if (w_dim_misaligned) begin
                            r_error    <= 1'b1;
                            r_err_code <= ERR_ALIGN;
                            r_state    <= S_ERR;
                        end else begin
                            r_array_clear <= 1'b1;
                            r_a_seen      <= 1'b0;
                            r_b_seen      <= 1'b0;
                            r_drain_cnt   <= '0;
                            r_state       <= S_CLEAR;
                        end
                    end

                    S_CLEAR: begin
                        r_gen_start <= 1'b1;
                        r_array_en  <= 1'b1;
                        r_state     <= S_RUN;
                    end

                    S_RUN: begin
                        r_a_seen <= w_a_all;
                        r_b_seen <= w_b_all;
                        if (w_both_done) begin
                            r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
                            r_state     <= S_DRAIN;
                        end
                    end

                    S_DRAIN: begin
                        if (w_drain_last) begin
                            r_array_en <= 1'b0;
                            r_wb_start <= 1'b1;
                            r_state    <= S_WB;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                        end
                    end

                    S_WB: begin
                        // wb_done may coincide with the wb_start cycle.
                        if (i_wb_done) begin
                            r_job_done <= 1'b1;
                            r_state    <= S_FIN;
                        end
                    end

                    S_FIN, S_ERR: begin
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end

                    default: begin
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_array_en  <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Scoreboard bench for mm_job_sequencer: each stimulus step queues the
// output events it should cause (kind, cycle, code); a negedge monitor turns
// DUT output activity into events and checks them against the queue in order.
module tb_mm_job_sequencer;

    localparam int EV_CLR  = 0;
    localparam int EV_GEN  = 1;
    localparam int EV_ENR  = 2;
    localparam int EV_ENF  = 3;
    localparam int EV_WB   = 4;
    localparam int EV_DONE = 5;
    localparam int EV_ERR  = 6;
    localparam int EV_RDY  = 7;

    typedef struct {
        int kind;
        int cyc;
        int code;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] gen_m, gen_n, gen_p;
    logic        gen_start, array_clear, array_en, wb_start;
    logic        busy, job_done, error;
    logic [1:0]  err_code;
    logic        a_done = 1'b0;
    logic        b_done = 1'b0;
    logic        wb_done = 1'b0;
    logic        abort = 1'b0;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    mm_job_sequencer_if cif();

    mm_job_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg           (cif),
        .o_gen_m       (gen_m),
        .o_gen_n       (gen_n),
        .o_gen_p       (gen_p),
        .o_gen_start   (gen_start),
        .i_a_done      (a_done),
        .i_b_done      (b_done),
        .o_array_clear (array_clear),
        .o_array_en    (array_en),
        .o_wb_start    (wb_start),
        .i_wb_done     (wb_done),
        .i_abort       (abort),
        .o_busy        (busy),
        .o_job_done    (job_done),
        .o_error       (error),
        .o_err_code    (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input int code);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int code);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d code=%0d", kind, cyc, code);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.code != code) begin
                failures++;
                $display("FAIL event got kind=%0d cyc=%0d code=%0d want kind=%0d cyc=%0d code=%0d",
                         kind, cyc, code, e.kind, e.cyc, e.code);
            end
        end
    endtask

    // Monitor: edge-detect levels, report pulses, skip while in reset.
    logic p_en  = 1'b0;
    logic p_err = 1'b0;
    logic p_rdy = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (array_clear)            got(EV_CLR, 0);
                if (gen_start)              got(EV_GEN, 0);
                if (array_en && !p_en)      got(EV_ENR, 0);
                if (!array_en && p_en)      got(EV_ENF, 0);
                if (wb_start)               got(EV_WB, 0);
                if (job_done)               got(EV_DONE, 0);
                if (error && !p_err)        got(EV_ERR, int'(err_code));
                if (cif.cfg_ready && !p_rdy) got(EV_RDY, 0);
            end
            p_en  = array_en;
            p_err = error;
            p_rdy = cif.cfg_ready;
        end
    end

    task automatic wait_until(input int at);
        while (cyc < at) tick();
        chk("stim_timing", 32'(cyc), 32'(at));
    endtask

    task automatic start_job(input logic [15:0] m, input logic [15:0] n,
                             input logic [15:0] p, output int t0);
        int w = 0;
        while (!cif.cfg_ready && w < 100) begin
            tick();
            w++;
        end
        chk("cfg_ready_wait", 32'(cif.cfg_ready), 32'd1);
        cif.cfg_valid = 1'b1;
        cif.cfg_m = m;
        cif.cfg_n = n;
        cif.cfg_p = p;
        t0 = cyc;
        tick();
        cif.cfg_valid = 1'b0;
    endtask

    task automatic drive_done(input int at, input bit a, input bit b);
        wait_until(at);
        a_done = a;
        b_done = b;
        tick();
        a_done = 1'b0;
        b_done = 1'b0;
    endtask

    task automatic drive_wb(input int at);
        wait_until(at);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
    endtask

    task automatic drive_abort(input int at);
        wait_until(at);
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic run_start(input int t0);
        expect_ev(EV_CLR, t0 + 2, 0);
        expect_ev(EV_GEN, t0 + 3, 0);
        expect_ev(EV_ENR, t0 + 3, 0);
    endtask

    task automatic err_job(input logic [15:0] m, input logic [15:0] n,
                           input logic [15:0] p, input int code);
        int t0;
        start_job(m, n, p, t0);
        expect_ev(EV_ERR, t0 + 2, code);
        expect_ev(EV_RDY, t0 + 3, 0);
    endtask

    initial begin
        int t0;
        int w;
        cif.cfg_valid = 1'b0;
        cif.cfg_m = '0;
        cif.cfg_n = '0;
        cif.cfg_p = '0;
        tick();
        tick();
        chk("rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gen_m", 32'(gen_m), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_pulses", {28'd0, gen_start, array_clear, array_en, wb_start}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Baseline job: a@+10, b@+12, wb_done@+25.
        start_job(16'd8, 16'd5, 16'd4, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 21, 0);
        expect_ev(EV_WB, t0 + 21, 0);
        expect_ev(EV_DONE, t0 + 26, 0);
        expect_ev(EV_RDY, t0 + 27, 0);
        chk("gen_m", 32'(gen_m), 32'd8);
        chk("gen_n", 32'(gen_n), 32'd5);
        chk("gen_p", 32'(gen_p), 32'd4);
        chk("busy_job", 32'(busy), 32'd1);
        drive_done(t0 + 10, 1'b1, 1'b0);
        drive_done(t0 + 12, 1'b0, 1'b1);
        drive_wb(t0 + 25);

        // Both done in one cycle; wb_done on the wb_start cycle.
        start_job(16'd4, 16'd3, 16'd8, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 14, 0);
        expect_ev(EV_WB, t0 + 14, 0);
        expect_ev(EV_DONE, t0 + 15, 0);
        expect_ev(EV_RDY, t0 + 16, 0);
        drive_done(t0 + 5, 1'b1, 1'b1);
        drive_wb(t0 + 14);

        // b first (on the gen_start cycle), a later.
        start_job(16'd12, 16'd7, 16'd4, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 16, 0);
        expect_ev(EV_WB, t0 + 16, 0);
        expect_ev(EV_DONE, t0 + 19, 0);
        expect_ev(EV_RDY, t0 + 20, 0);
        drive_done(t0 + 3, 1'b0, 1'b1);
        drive_done(t0 + 7, 1'b1, 1'b0);
        drive_wb(t0 + 18);

        // Dimension errors.
        err_job(16'd0, 16'd5, 16'd4, 1);
        err_job(16'd6, 16'd5, 16'd4, 2);
        err_job(16'd3, 16'd0, 16'd4, 1);
        err_job(16'd4, 16'd3, 16'd6, 2);

        // n at buffer capacity is legal; accept clears the sticky error.
        start_job(16'd4, 16'd1024, 16'd8, t0);
        chk("err_clr_on_accept", 32'(error), 32'd0);
        chk("code_clr_on_accept", 32'(err_code), 32'd0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 12, 0);
        expect_ev(EV_WB, t0 + 12, 0);
        expect_ev(EV_DONE, t0 + 14, 0);
        expect_ev(EV_RDY, t0 + 15, 0);
        drive_done(t0 + 3, 1'b1, 1'b1);
        drive_wb(t0 + 13);

        err_job(16'd4, 16'd1025, 16'd4, 2);

        // Abort in DRAIN.
        start_job(16'd4, 16'd2, 16'd4, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 9, 0);
        expect_ev(EV_ERR, t0 + 9, 3);
        expect_ev(EV_RDY, t0 + 9, 0);
        drive_done(t0 + 4, 1'b1, 1'b1);
        drive_abort(t0 + 8);
        chk("abort_code", 32'(err_code), 32'd3);

        // Stray a_done in IDLE, then a job that needs both.
        drive_done(cyc + 1, 1'b1, 1'b0);
        chk("stray_busy", 32'(busy), 32'd0);
        start_job(16'd8, 16'd4, 16'd8, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 17, 0);
        expect_ev(EV_WB, t0 + 17, 0);
        expect_ev(EV_DONE, t0 + 18, 0);
        expect_ev(EV_RDY, t0 + 19, 0);
        drive_done(t0 + 5, 1'b0, 1'b1);
        drive_done(t0 + 8, 1'b1, 1'b0);
        drive_wb(t0 + 17);

        // abort in IDLE is ignored.
        w = 0;
        while (!cif.cfg_ready && w < 100) begin
            tick();
            w++;
        end
        drive_abort(cyc);
        chk("idle_abort_err", 32'(error), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Reset during WB, then a fresh job.
        start_job(16'd8, 16'd8, 16'd8, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 12, 0);
        expect_ev(EV_WB, t0 + 12, 0);
        drive_done(t0 + 3, 1'b1, 1'b1);
        wait_until(t0 + 14);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cif.cfg_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gen_n", 32'(gen_n), 32'd0);
        chk("mid_rst_outs", {27'd0, gen_start, array_clear, array_en, wb_start, job_done}, 32'd0);
        tick();
        reset_n = 1'b1;
        start_job(16'd4, 16'd2, 16'd4, t0);
        run_start(t0);
        expect_ev(EV_ENF, t0 + 13, 0);
        expect_ev(EV_WB, t0 + 13, 0);
        expect_ev(EV_DONE, t0 + 16, 0);
        expect_ev(EV_RDY, t0 + 17, 0);
        drive_done(t0 + 4, 1'b1, 1'b1);
        drive_wb(t0 + 15);

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
